// File: rtl/sr_seq_pkg.sv
// Shared types and constants for the SR latch sequencer.
package sr_seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT_PULSE = 3'd0,
        ST_INIT_GAP   = 3'd1,
        ST_IDLE       = 3'd2,
        ST_PULSE      = 3'd3,
        ST_GAP        = 3'd4,
        ST_CHECK      = 3'd5
    } sr_state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    // Channel index width; a single-channel bank still gets a 1-bit index.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the shared pulse/gap down-counter.
    function automatic int cnt_w(input int p, input int g);
        int m;
        m = (p > g) ? p : g;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter timing both the S/R pulse and the guard gap.
// The terminal count flags the last cycle of the current interval.
module sr_pulse_timer #(
    parameter int              CNT_W   = 2,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/sr_latch_sequencer.sv
// Sequencer driving timed S/R pulses into a bank of set/reset latches.
// S and R of one latch are never driven together; the whole bank is
// cleared after reset. Optional readback check: SR_READBACK_CHECK_EN.
module sr_latch_sequencer
    import sr_seq_pkg::*;
#(
    parameter int  CH      = 4,
    parameter int  PULSE_W = 2,
    parameter int  GAP_W   = 1,
    localparam int CH_W    = ch_idx_w(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [CH_W-1:0] cmd_ch,
    input  logic            cmd_op,
    output logic [CH-1:0]   s,
    output logic [CH-1:0]   r,
    output logic [CH-1:0]   q_shadow,
    output logic            busy,
    output logic            done,
    input  logic [CH-1:0]   q_in,
    output logic            err
);

    localparam int               CNT_W    = cnt_w(PULSE_W, GAP_W);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

    sr_state_t        r_state;
    logic             r_armed;
    logic [CH_W-1:0]  r_ch;
    logic             r_op;
    logic [CH-1:0]    r_s;
    logic [CH-1:0]    r_r;
    logic [CH-1:0]    r_q;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    sr_state_t        w_state_nxt;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_en;
    logic             w_tc;
    logic             w_accept;
    logic             w_finish;
    logic             w_ch_ok;
    logic             w_op_nxt;
    logic             w_err_nxt;
    logic [CH-1:0]    w_cmd_mask;
    logic [CH-1:0]    w_cur_mask;
    logic [CH-1:0]    w_mask_nxt;

    assign w_ch_ok    = (int'(cmd_ch) < CH);
    assign w_cmd_mask = CH'(1) << cmd_ch;
    assign w_cur_mask = CH'(1) << r_ch;
    assign w_mask_nxt = w_accept ? w_cmd_mask : w_cur_mask;
    assign w_op_nxt   = w_accept ? cmd_op : r_op;

    sr_pulse_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (PULSE_LD)
    ) u_timer (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_tc       (w_tc)
    );

    // Next-state, timer control and command acceptance.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = PULSE_LD;
        w_tmr_en    = 1'b0;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_INIT_PULSE: begin
                // The first cycle after reset release still shows the reset
                // outputs, so the init pulse only starts counting once armed.
                if (r_armed) begin
                    w_tmr_en = 1'b1;
                    if (w_tc) begin
                        w_state_nxt = ST_INIT_GAP;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = GAP_LD;
                    end
                end
            end
            ST_INIT_GAP: begin
                w_tmr_en = 1'b1;
                if (w_tc) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cmd_valid && r_ready) begin
                    w_accept = 1'b1;
                    if (w_ch_ok) begin
                        w_state_nxt = ST_PULSE;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = PULSE_LD;
                    end else begin
                        // Out-of-range channel: swallowed, completes at once.
                        w_finish = 1'b1;
                    end
                end
            end
            ST_PULSE: begin
                w_tmr_en = 1'b1;
                if (w_tc) begin
                    w_state_nxt = ST_GAP;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = GAP_LD;
                end
            end
            ST_GAP: begin
                w_tmr_en = 1'b1;
                if (w_tc) begin
`ifdef SR_READBACK_CHECK_EN
                    w_state_nxt = ST_CHECK;
`else
                    w_state_nxt = ST_IDLE;
                    w_finish    = 1'b1;
`endif
                end
            end
`ifdef SR_READBACK_CHECK_EN
            ST_CHECK: begin
                w_state_nxt = ST_IDLE;
                w_finish    = 1'b1;
            end
`endif
            default: begin
                w_state_nxt = ST_INIT_PULSE;
                w_tmr_load  = 1'b1;
                w_tmr_val   = PULSE_LD;
            end
        endcase
    end

`ifdef SR_READBACK_CHECK_EN
    // Q is sampled at the end of the last gap cycle so the mismatch flag is
    // registered and visible during CHECK itself.
    assign w_err_nxt = (r_state == ST_GAP) && w_tc &&
                       ((|(q_in & w_cur_mask)) != r_op);
`else
    logic w_unused_q_in;
    assign w_unused_q_in = ^q_in;
    assign w_err_nxt     = 1'b0;
`endif

    // FSM state and captured command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT_PULSE;
            r_armed <= 1'b0;
            r_ch    <= '0;
            r_op    <= OP_CLR;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= 1'b1;
            if (w_accept) begin
                r_ch <= cmd_ch;
                r_op <= cmd_op;
            end
        end
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s     <= '0;
            r_r     <= '0;
            r_q     <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept && w_ch_ok) begin
                r_q <= (cmd_op == OP_CLR) ? (r_q & ~w_cmd_mask) : (r_q | w_cmd_mask);
            end
            r_s <= ((w_state_nxt == ST_PULSE) && (w_op_nxt == OP_SET)) ? w_mask_nxt : '0;
            if (w_state_nxt == ST_INIT_PULSE) begin
                r_r <= '1;
            end else if ((w_state_nxt == ST_PULSE) && (w_op_nxt == OP_CLR)) begin
                r_r <= w_mask_nxt;
            end else begin
                r_r <= '0;
            end
            r_ready <= (w_state_nxt == ST_IDLE);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_finish;
            r_err   <= w_err_nxt;
        end
    end

    assign s         = r_s;
    assign r         = r_r;
    assign q_shadow  = r_q;
    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Bench for sr_latch_sequencer: directed scenarios plus random commands,
// checked against a cycle-window model of the pulse/gap/done schedule.
module tb_sr_latch_sequencer;

    localparam int CH = 4;
    localparam int PW = 2;
    localparam int GW = 1;
`ifdef SR_READBACK_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int NEVER = 32'h7fff_ffff;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_op, cmd_ready, busy, done, err;
    logic [1:0] cmd_ch;
    logic [3:0] s, r, q_shadow, q_in;

    logic       c3_valid, c3_op, c3_ready, c3_busy, c3_done, c3_err;
    logic [1:0] c3_ch;
    logic [2:0] c3_s, c3_r, c3_q, c3_qin;

    always #5 clk = ~clk;

    sr_latch_sequencer #(.CH(CH), .PULSE_W(PW), .GAP_W(GW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_op(cmd_op), .s(s), .r(r), .q_shadow(q_shadow),
        .busy(busy), .done(done), .q_in(q_in), .err(err)
    );

    sr_latch_sequencer #(.CH(3), .PULSE_W(PW), .GAP_W(GW)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
        .cmd_ch(c3_ch), .cmd_op(c3_op), .s(c3_s), .r(c3_r), .q_shadow(c3_q),
        .busy(c3_busy), .done(c3_done), .q_in(c3_qin), .err(c3_err)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Model: the schedule of the last command expressed as cycle windows.
    bit         m_rst;
    int         m_init0, m_free, m_T, m_done, m_ch;
    bit         m_ok, m_op, m_errbit, force0;
    logic [3:0] m_qs, q_lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    endtask

    task automatic check_cycle();
        logic [3:0] es, er;
        bit erdy, edone, eerr;
        es = '0; er = '0; erdy = 1'b0; edone = 1'b0; eerr = 1'b0;
        if (!m_rst) begin
            if (cyc >= m_init0 && cyc < m_init0 + PW) er = '1;
            if (m_T >= 0 && m_ok && cyc > m_T && cyc <= m_T + PW) begin
                if (m_op) es = 4'(1 << m_ch);
                else      er = 4'(1 << m_ch);
            end
            erdy  = (cyc >= m_free);
            edone = (m_T >= 0) && (cyc == m_done);
            eerr  = (CHK != 0) && (m_T >= 0) && m_ok && (cyc == m_T + PW + GW + 1) && m_errbit;
        end
        chk("s", 32'(s), 32'(es));
        chk("r", 32'(r), 32'(er));
        chk("cmd_ready", 32'(cmd_ready), 32'(erdy));
        chk("busy", 32'(busy), 32'(!erdy));
        chk("done", 32'(done), 32'(edone));
        chk("err", 32'(err), 32'(eerr));
        chk("q_shadow", 32'(q_shadow), m_rst ? 32'd0 : 32'(m_qs));
        chk("s_and_r", 32'(s & r), 32'd0);
        // Behavioural SR latch bank fed by the expected drive.
        q_lat = (q_lat | es) & ~er;
        q_in  = q_lat;
        if (force0) q_in[1] = 1'b0;
        if (m_T >= 0 && cyc == m_T + PW + GW) m_errbit = (q_in[m_ch] != m_op);
    endtask

    task automatic drive(input bit v, input int ch, input bit op);
        cmd_valid = v;
        cmd_ch    = 2'(ch);
        cmd_op    = op;
        if (!m_rst && v && cyc >= m_free) begin
            m_T    = cyc;
            m_ch   = ch;
            m_op   = op;
            m_ok   = (ch < CH);
            m_free = m_ok ? cyc + PW + GW + 1 + CHK : cyc + 1;
            m_done = m_free;
            if (m_ok) m_qs[ch] = op;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle(input bit v, input int ch, input bit op);
        check_cycle();
        drive(v, ch, op);
        tick();
    endtask

    task automatic release_reset();
        rst_n   = 1'b1;
        m_rst   = 1'b0;
        m_init0 = cyc + 1;
        m_free  = m_init0 + PW + GW;
    endtask

    initial begin
        int t0;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_ch = '0; cmd_op = 1'b0;
        c3_valid = 1'b0; c3_ch = '0; c3_op = 1'b0; c3_qin = '0;
        q_in = '0; q_lat = '0; force0 = 1'b0;
        m_rst = 1'b1; m_qs = '0; m_T = -1; m_init0 = 0; m_free = NEVER;
        m_done = -1; m_ch = 0; m_ok = 1'b0; m_op = 1'b0; m_errbit = 1'b0;
        repeat (2) tick();

        // Reset state, then release and watch the bank-clear sequence.
        check_cycle();
        chk("d3_rst_ready", 32'(c3_ready), 32'd0);
        release_reset();
        cycle(1'b0, 0, 1'b0);
        chk("init_r_first", 32'(r), 32'hf);
        chk("d3_init_r", 32'(c3_r), 32'h7);
        while (cyc < m_free) cycle(1'b0, 0, 1'b0);
        chk("init_ready", 32'(cmd_ready), 32'd1);
        chk("init_no_done", 32'(done), 32'd0);
        chk("d3_init_ready", 32'(c3_ready), 32'd1);

        // Out-of-range channel on the 3-channel instance is dropped.
        c3_valid = 1'b1; c3_ch = 2'd3; c3_op = 1'b1;
        cycle(1'b0, 0, 1'b0);
        c3_valid = 1'b0;
        chk("oor_done", 32'(c3_done), 32'd1);
        chk("oor_s", 32'(c3_s | c3_r), 32'd0);
        chk("oor_qs", 32'(c3_q), 32'd0);
        chk("oor_ready", 32'(c3_ready), 32'd1);
        c3_valid = 1'b1; c3_ch = 2'd2; c3_op = 1'b1;
        cycle(1'b0, 0, 1'b0);
        c3_valid = 1'b0;
        chk("d3_set2_s", 32'(c3_s), 32'h4);
        chk("d3_done_once", 32'(c3_done), 32'd0);

        // Set channel 2.
        while (cyc < m_free) cycle(1'b0, 0, 1'b0);
        cycle(1'b1, 2, 1'b1);
        chk("set2_s_t1", 32'(s), 32'h4);
        cycle(1'b0, 0, 1'b0);
        chk("set2_s_t2", 32'(s), 32'h4);
        cycle(1'b0, 0, 1'b0);
        chk("set2_gap", 32'(s | r), 32'd0);
        while (cyc < m_free) cycle(1'b0, 0, 1'b0);
        chk("set2_done", 32'(done), 32'd1);
        chk("set2_qs", 32'(q_shadow), 32'h4);
        chk("set2_latch", 32'(q_lat[2]), 32'd1);

        // Back-to-back set/clear of channel 0 with valid held.
        t0 = cyc;
        cycle(1'b1, 0, 1'b1);
        while (cyc < t0 + 5) cycle(1'b1, 0, 1'b0);
        chk("b2b_r_t5", 32'(r), 32'h1);
        cycle(1'b0, 0, 1'b0);
        chk("b2b_r_t6", 32'(r), 32'h1);
        cycle(1'b0, 0, 1'b0);
        chk("b2b_r_t7", 32'(r), 32'h0);
        while (cyc < m_free) cycle(1'b0, 0, 1'b0);
        chk("b2b_qs", 32'(q_shadow), 32'h4);

`ifdef SR_READBACK_CHECK_EN
        // Readback mismatch on channel 1.
        force0 = 1'b1;
        t0 = cyc;
        cycle(1'b1, 1, 1'b1);
        while (cyc < t0 + 4) cycle(1'b0, 0, 1'b0);
        chk("rb_err", 32'(err), 32'd1);
        chk("rb_no_done", 32'(done), 32'd0);
        cycle(1'b0, 0, 1'b0);
        chk("rb_done", 32'(done), 32'd1);
        chk("rb_qs", 32'(q_shadow[1]), 32'd1);
        force0 = 1'b0;
        while (cyc < m_free) cycle(1'b0, 0, 1'b0);
`endif

        // Random command traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(bit'($urandom % 3 != 0), int'($urandom % 4), bit'($urandom % 2));
        end
        while (cyc < m_free) cycle(1'b0, 0, 1'b0);

        // Reset asserted in the middle of a set pulse.
        cycle(1'b1, 1, 1'b1);
        chk("mid_s_before", 32'(s), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_s_async", 32'(s), 32'd0);
        chk("mid_r_async", 32'(r), 32'd0);
        m_rst = 1'b1; m_qs = '0; m_T = -1; m_free = NEVER;
        tick();
        check_cycle();
        release_reset();
        while (cyc < m_free) cycle(1'b0, 0, 1'b0);
        chk("mid_qs_cleared", 32'(q_shadow), 32'd0);
        chk("mid_ready", 32'(cmd_ready), 32'd1);
        cycle(1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sr_latch_sequencer.md
# sr_latch_sequencer

Controller for a bank of CH set/reset gate latches. Accepts one set/clear command at a time over a valid/ready handshake and drives a timed S or R pulse into the addressed latch, followed by a guard gap. It keeps a shadow copy of every latch state and clears the whole bank after reset. The block guarantees that S and R of a latch are never asserted together, since that input is the forbidden case (Q/Qbar undefined). It sits between the register/command logic and the latching-output gate bank.

## Interface
Parameters:
- CH, 4 — number of latch channels (≥1)
- PULSE_W, 2 — S/R pulse width in clock cycles (≥1)
- GAP_W, 1 — all-low guard cycles after each pulse (≥1)

Ports:
- clk  in  1  — single clock, rising edge
- rst_n  in  1  — reset, asynchronous assert, active-low
- cmd_valid  in  1  — command present
- cmd_ready  out  1  — block can accept a command
- cmd_ch  in  $clog2(CH) (min 1)  — target channel
- cmd_op  in  1  — 1 = set, 0 = clear
- s  out  CH  — set drive, one bit per latch
- r  out  CH  — reset drive, one bit per latch
- q_shadow  out  CH  — last commanded state per latch
- busy  out  1  — high in any state other than IDLE
- done  out  1  — one-cycle pulse when a command completes
- q_in  in  CH  — latch Q readback (used only with the readback-check macro)
- err  out  1  — one-cycle readback mismatch pulse

## Operation
- FSM states: INIT_PULSE, INIT_GAP, IDLE, PULSE, GAP, CHECK (CHECK exists only with the macro).
- Reset (rst_n low, async): s=0, r=0, q_shadow=0, done=0, err=0, cmd_ready=0, busy=1, state=INIT_PULSE, counter loaded.
- INIT_PULSE: r = all ones for PULSE_W cycles. INIT_GAP: s=r=0 for GAP_W cycles. Then IDLE. No done is issued for the init sequence.
- IDLE: cmd_ready=1, busy=0. On cmd_valid&&cmd_ready, latch cmd_ch/cmd_op and go to PULSE.
- PULSE: drive s[ch] (op=1) or r[ch] (op=0) for PULSE_W cycles. All other bits are 0. Update q_shadow[ch]=op on entry.
- GAP: s=r=0 for GAP_W cycles. Then CHECK (macro) or IDLE with done=1.
- cmd_ch ≥ CH: the command is accepted and dropped. There is no S/R activity and q_shadow is unchanged. done pulses in the cycle after acceptance.
- A redundant command (target already in the commanded state) is executed normally.
- Invariants, which hold in every cycle: (s & r)==0. In normal operation, s|r has at most one bit set.
- Reset asserted mid-pulse forces s/r low immediately and restarts INIT_PULSE.

## Timing
- Command accepted at the edge ending cycle T.
- Pulse active in cycles T+1 … T+PULSE_W.
- Gap in cycles T+PULSE_W+1 … T+PULSE_W+GAP_W.
- Without the macro: IDLE, done=1 and cmd_ready=1 in cycle T+PULSE_W+GAP_W+1. Throughput is one command per PULSE_W+GAP_W+1 cycles.
- With the macro: CHECK is cycle T+PULSE_W+GAP_W+1. done lands one cycle later.
- Init after rst_n rises: cmd_ready first high after PULSE_W+GAP_W cycles.
- Pulse/gap counter: down-counter of width $clog2(max(PULSE_W,GAP_W)+1). It is loaded with W−1 and terminates at 0.
- All outputs are registered.

## Configuration
- Macro: SR_READBACK_CHECK_EN.
- Defined: CHECK state samples q_in[ch]. If q_in[ch]≠op, err pulses high for that cycle. done follows in the next cycle, and q_shadow keeps the commanded value.
- Undefined: no CHECK state, q_in is ignored, and err is tied 0.

## Structure
- Package sr_seq_pkg:
  - state enum sr_state_t
  - constants OP_SET=1'b1 and OP_CLR=1'b0
- One sub-module, sr_pulse_timer: parameterised down-counter with load/terminal-count outputs, shared by PULSE and GAP.

## Test plan
- Reset release, CH=4, PULSE_W=2, GAP_W=1 -> r=4'b1111 for 2 cycles, then 1 gap cycle. Then cmd_ready=1, q_shadow=0, no done.
- Set ch 2, accepted at T -> s=4'b0100 at T+1..T+2, s=r=0 at T+3, done and ready at T+4, q_shadow=4'b0100. Drive a modelled SR latch: Q[2]=1.
- Back-to-back set ch 0 then clear ch 0 with cmd_valid held -> second accept at T+4. r[0] high at T+5..T+6. (s&r)==0 checked every cycle.
- cmd_ch=5 with CH=4 would be out of range but is unencodable with a 2-bit cmd_ch; use CH=3 and cmd_ch=3 -> no s/r activity, done at T+1.
- rst_n pulsed low during PULSE of a set -> s drops to 0 asynchronously. Init sequence reruns and q_shadow=0.
- With SR_READBACK_CHECK_EN: set ch 1 while q_in[1] is forced to 0 -> err=1 at T+4, done at T+5. With correct q_in, err stays 0.
